// File: rtl/stim_sequencer_if.sv
// Bus bundle between the vector host, the stimulus sequencer and the FSM under check.
interface stim_sequencer_if #(
    parameter int unsigned IN_LEN  = 8,
    parameter int unsigned OUT_LEN = 19,
    parameter int unsigned AW      = 10
);
    logic                load_we;
    logic [AW-1:0]       load_addr;
    logic [IN_LEN:0]     load_data;
    logic [AW:0]         length;
    logic                loop_en;
    logic                start;
    logic                stop;
    logic                pause;
    logic [OUT_LEN-1:0]  match_mask;
    logic [OUT_LEN-1:0]  match_val;
    logic [OUT_LEN-1:0]  dut_out;
    logic                dut_rst;
    logic [IN_LEN-1:0]   dut_in;
    logic                busy;
    logic                done;
    logic                hit;
    logic [AW-1:0]       hit_idx;
    logic [7:0]          loop_cnt;
    logic [31:0]         applied_cnt;

    // Host side: loads the table, controls playback, closes the loop from the DUT output.
    modport master (
        output load_we, load_addr, load_data, length, loop_en, start, stop, pause,
               match_mask, match_val, dut_out,
        input  dut_rst, dut_in, busy, done, hit, hit_idx, loop_cnt, applied_cnt
    );

    // Sequencer side.
    modport slave (
        input  load_we, load_addr, load_data, length, loop_en, start, stop, pause,
               match_mask, match_val, dut_out,
        output dut_rst, dut_in, busy, done, hit, hit_idx, loop_cnt, applied_cnt
    );
endinterface

// File: rtl/stim_sequencer.sv
// Replays stored {rst, in} vectors into the FSM under check and stops on a masked output match.
module stim_sequencer #(
    parameter int unsigned IN_LEN  = 8,
    parameter int unsigned OUT_LEN = 19,
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned AW      = 10
) (
    input  logic            clk,
    input  logic            rst,
    stim_sequencer_if.slave bus
);
    localparam int unsigned VW = IN_LEN + 1;
    localparam int unsigned LW = AW + 1;
    localparam logic [VW-1:0] IDLE_VEC = {1'b1, {IN_LEN{1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    logic [VW-1:0] mem [DEPTH];

    state_t        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW-1:0] drv_idx_q, drv_idx_d;
    logic [AW-1:0] hit_idx_q, hit_idx_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] eff_len;
    logic          loop_q, loop_d;
    logic          rd_done_q, rd_done_d;
    logic          drv_valid_q, drv_valid_d;
    logic          done_q, done_d;
    logic          hit_q, hit_d;
    logic          busy_q;
    logic [7:0]    loop_cnt_q, loop_cnt_d;
    logic [31:0]   applied_q, applied_d;
    logic [VW-1:0] vec_q;
    logic          issue;
    logic          park;
    logic          vec_match;
    logic          last_idx;
    logic          wr_ok;

    assign eff_len   = (32'(bus.length) > DEPTH) ? LW'(DEPTH) : bus.length;
    assign vec_match = ((bus.dut_out ^ bus.match_val) & bus.match_mask) == OUT_LEN'(0);
    assign last_idx  = (LW'(ptr_q) + LW'(1)) == len_q;
    assign wr_ok     = bus.load_we && ((state_q == IDLE) || (state_q == DONE))
                       && (32'(bus.load_addr) < DEPTH);

    assign bus.dut_rst     = vec_q[IN_LEN];
    assign bus.dut_in      = vec_q[IN_LEN-1:0];
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.hit         = hit_q;
    assign bus.hit_idx     = hit_idx_q;
    assign bus.loop_cnt    = loop_cnt_q;
    assign bus.applied_cnt = applied_q;

    // Table write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[bus.load_addr] <= bus.load_data;
        end
    end

    // State and output registers; the table read register doubles as the DUT drive register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            drv_idx_q   <= '0;
            hit_idx_q   <= '0;
            len_q       <= '0;
            loop_q      <= 1'b0;
            rd_done_q   <= 1'b0;
            drv_valid_q <= 1'b0;
            done_q      <= 1'b0;
            hit_q       <= 1'b0;
            busy_q      <= 1'b0;
            loop_cnt_q  <= '0;
            applied_q   <= '0;
            vec_q       <= IDLE_VEC;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            drv_idx_q   <= drv_idx_d;
            hit_idx_q   <= hit_idx_d;
            len_q       <= len_d;
            loop_q      <= loop_d;
            rd_done_q   <= rd_done_d;
            drv_valid_q <= drv_valid_d;
            done_q      <= done_d;
            hit_q       <= hit_d;
            busy_q      <= (state_d == RUN) || (state_d == PAUSE);
            loop_cnt_q  <= loop_cnt_d;
            applied_q   <= applied_d;
            if (issue) begin
                vec_q <= mem[ptr_q];
            end else if (park) begin
                vec_q <= IDLE_VEC;
            end
        end
    end

    // Next-state: stop > match > end-of-table > pause > advance; start only from IDLE/DONE.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        drv_idx_d   = drv_idx_q;
        hit_idx_d   = hit_idx_q;
        len_d       = len_q;
        loop_d      = loop_q;
        rd_done_d   = rd_done_q;
        drv_valid_d = drv_valid_q;
        done_d      = done_q;
        hit_d       = hit_q;
        loop_cnt_d  = loop_cnt_q;
        applied_d   = applied_q;
        issue       = 1'b0;
        park        = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (bus.stop) begin
                    state_d   = IDLE;
                    done_d    = 1'b0;
                    hit_d     = 1'b0;
                    hit_idx_d = '0;
                    park      = 1'b1;
                end else if (bus.start) begin
                    len_d       = eff_len;
                    loop_d      = bus.loop_en;
                    ptr_d       = '0;
                    rd_done_d   = 1'b0;
                    drv_valid_d = 1'b0;
                    done_d      = 1'b0;
                    hit_d       = 1'b0;
                    hit_idx_d   = '0;
                    loop_cnt_d  = '0;
                    applied_d   = '0;
                    if (eff_len == LW'(0)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN, PAUSE: begin
                if (bus.stop) begin
                    state_d     = IDLE;
                    done_d      = 1'b0;
                    hit_d       = 1'b0;
                    hit_idx_d   = '0;
                    drv_valid_d = 1'b0;
                    park        = 1'b1;
                end else if ((state_q == RUN) && drv_valid_q && vec_match) begin
                    state_d     = DONE;
                    done_d      = 1'b1;
                    hit_d       = 1'b1;
                    hit_idx_d   = drv_idx_q;
                    drv_valid_d = 1'b0;
                    park        = 1'b1;
                end else if (rd_done_q) begin
                    state_d     = DONE;
                    done_d      = 1'b1;
                    drv_valid_d = 1'b0;
                    park        = 1'b1;
                end else if (bus.pause) begin
                    state_d = PAUSE;
                end else begin
                    // Resuming from PAUSE issues immediately so the held vector is not stretched.
                    state_d     = RUN;
                    issue       = 1'b1;
                    drv_valid_d = 1'b1;
                    drv_idx_d   = ptr_q;
                    if (applied_q != 32'hFFFF_FFFF) begin
                        applied_d = applied_q + 32'd1;
                    end
                    if (last_idx) begin
                        if (loop_q) begin
                            ptr_d = '0;
                            if (loop_cnt_q != 8'hFF) begin
                                loop_cnt_d = loop_cnt_q + 8'd1;
                            end
                        end else begin
                            rd_done_d = 1'b1;
                        end
                    end else begin
                        ptr_d = ptr_q + AW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_stim_sequencer.sv
// Self-checking bench for stim_sequencer with an output-echo DUT stub and a sequence-level model.
module tb_stim_sequencer;
    localparam int unsigned IN_LEN  = 8;
    localparam int unsigned OUT_LEN = 19;
    localparam int unsigned DEPTH   = 1024;
    localparam int unsigned AW      = 10;
    localparam logic [OUT_LEN-1:0] ALL_ONES = '1;
    localparam logic [OUT_LEN-1:0] UNREACH  = 19'h40000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    stim_sequencer_if #(.IN_LEN(IN_LEN), .OUT_LEN(OUT_LEN), .AW(AW)) bus ();

    // Stub FSM under check: output echoes its data input.
    assign bus.dut_out = OUT_LEN'(bus.dut_in);

    stim_sequencer #(.IN_LEN(IN_LEN), .OUT_LEN(OUT_LEN), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [IN_LEN:0] tbl [DEPTH];
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int addr, input logic [IN_LEN:0] data);
        bus.load_we   = 1'b1;
        bus.load_addr = AW'(addr);
        bus.load_data = data;
        step();
        bus.load_we   = 1'b0;
        tbl[addr]     = data;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_vec"}, {bus.dut_rst, bus.dut_in}, {1'b1, 8'h00});
        chk({tag, "_regs"}, {bus.busy, bus.done, bus.hit, bus.hit_idx, bus.loop_cnt, bus.applied_cnt}, 64'd0);
    endtask

    function automatic bit echo_hits(input int idx, input logic [OUT_LEN-1:0] m, input logic [OUT_LEN-1:0] v);
        logic [OUT_LEN-1:0] o;
        o = OUT_LEN'(tbl[idx][IN_LEN-1:0]);
        return ((o ^ v) & m) == '0;
    endfunction

    // Model: list the vector indices that should be played (wrap, first hit, stop), then
    // replay that list cycle by cycle, holding the vector while pause is asserted.
    task automatic run_case(input string name, input int len, input bit lp,
                            input logic [OUT_LEN-1:0] m, input logic [OUT_LEN-1:0] v,
                            input int pause_at, input int pause_len, input int stop_after);
        int  seq[$];
        int  L, k, idx, wraps, exp_hidx, reps;
        bit  exp_hit, stopped, stop_now;
        L        = (len > int'(DEPTH)) ? int'(DEPTH) : len;
        k        = 0;
        wraps    = 0;
        exp_hit  = 1'b0;
        exp_hidx = 0;
        if (L > 0) begin
            while (k < 5000) begin
                if (!lp && k >= L) break;
                if (stop_after > 0 && k >= stop_after) break;
                idx = lp ? (k % L) : k;
                seq.push_back(idx);
                if (lp && idx == L - 1 && wraps < 255) wraps++;
                if (echo_hits(idx, m, v)) begin
                    exp_hit  = 1'b1;
                    exp_hidx = idx;
                    break;
                end
                k++;
            end
        end
        stopped = (stop_after > 0) && (seq.size() == stop_after);

        bus.length     = (AW+1)'(len);
        bus.loop_en    = lp;
        bus.match_mask = m;
        bus.match_val  = v;
        bus.start      = 1'b1;
        step();
        bus.start = 1'b0;
        if (L > 0) begin
            chk({name, "_lead"}, {bus.busy, bus.dut_rst, bus.dut_in}, {1'b1, 1'b1, 8'h00});
            step();
            for (int j = 0; j < seq.size(); j++) begin
                reps     = (j == pause_at && j != seq.size() - 1) ? pause_len : 0;
                stop_now = (stop_after > 0) && (j == stop_after - 1);
                for (int r = 0; r <= reps; r++) begin
                    bus.pause = (r < reps);
                    bus.stop  = stop_now;
                    chk($sformatf("%s_vec%0d", name, j), {bus.busy, bus.dut_rst, bus.dut_in}, {1'b1, tbl[seq[j]]});
                    step();
                end
            end
            bus.pause = 1'b0;
            bus.stop  = 1'b0;
        end
        if (stopped) begin
            chk({name, "_end"}, {bus.busy, bus.done, bus.hit, bus.hit_idx, bus.dut_rst, bus.dut_in},
                {1'b0, 1'b0, 1'b0, 10'd0, 1'b1, 8'h00});
        end else begin
            chk({name, "_end"}, {bus.busy, bus.done, bus.hit, bus.hit_idx, bus.dut_rst, bus.dut_in},
                {1'b0, 1'b1, exp_hit, AW'(exp_hidx), 1'b1, 8'h00});
        end
        chk({name, "_cnt"}, {bus.loop_cnt, bus.applied_cnt}, {8'(wraps), 32'(seq.size())});
    endtask

    initial begin
        int          len, tgt, stop_after, pause_at, pause_len;
        bit          lp, nohit;
        logic [OUT_LEN-1:0] m, v;

        rst            = 1'b1;
        bus.load_we    = 1'b0;
        bus.load_addr  = '0;
        bus.load_data  = '0;
        bus.length     = '0;
        bus.loop_en    = 1'b0;
        bus.start      = 1'b0;
        bus.stop       = 1'b0;
        bus.pause      = 1'b0;
        bus.match_mask = '0;
        bus.match_val  = '0;
        step();
        step();
        check_reset_outputs("reset");
        rst = 1'b0;

        for (int i = 0; i < int'(DEPTH); i++) begin
            load(i, (IN_LEN+1)'($urandom));
        end
        load(0, 9'h100);
        load(1, 9'h0A5);
        load(2, 9'h03C);
        load(3, 9'h0FF);

        run_case("plain4", 4, 1'b0, ALL_ONES, UNREACH, -1, 0, 0);
        run_case("hit3c", 4, 1'b0, 19'h000FF, 19'h0003C, -1, 0, 0);
        step();
        step();
        chk("done_hold", {bus.busy, bus.done, bus.hit, bus.hit_idx, bus.applied_cnt}, {1'b0, 1'b1, 1'b1, 10'd2, 32'd3});
        bus.stop  = 1'b1;
        bus.start = 1'b1;
        step();
        bus.stop  = 1'b0;
        bus.start = 1'b0;
        chk("stop_beats_start", {bus.busy, bus.done, bus.hit, bus.hit_idx, bus.dut_rst}, {1'b0, 1'b0, 1'b0, 10'd0, 1'b1});
        step();
        chk("stop_stays_idle", {bus.busy, bus.done}, 2'b00);

        run_case("loop3", 3, 1'b1, ALL_ONES, UNREACH, -1, 0, 10);
        run_case("pause5", 4, 1'b0, ALL_ONES, UNREACH, 1, 5, 0);
        run_case("mask0", 4, 1'b0, '0, UNREACH, -1, 0, 0);
        run_case("hitlast", 4, 1'b0, 19'h000FF, 19'h000FF, -1, 0, 0);
        run_case("len0", 0, 1'b0, ALL_ONES, UNREACH, -1, 0, 0);
        run_case("len2000", 2000, 1'b0, ALL_ONES, UNREACH, -1, 0, 0);

        // Reset mid-run; write and start during RUN must be ignored.
        bus.length     = (AW+1)'(20);
        bus.loop_en    = 1'b0;
        bus.match_mask = ALL_ONES;
        bus.match_val  = UNREACH;
        bus.start      = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        for (int j = 0; j < 8; j++) begin
            chk($sformatf("mid_vec%0d", j), {bus.busy, bus.dut_rst, bus.dut_in}, {1'b1, tbl[j]});
            bus.start     = (j == 2);
            bus.load_we   = (j == 3);
            bus.load_addr = AW'(5);
            bus.load_data = ~tbl[5];
            rst           = (j == 7);
            step();
        end
        rst         = 1'b0;
        bus.start   = 1'b0;
        bus.load_we = 1'b0;
        check_reset_outputs("midrst");
        run_case("replay", 20, 1'b0, ALL_ONES, UNREACH, -1, 0, 0);

        for (int t = 0; t < 10; t++) begin
            len        = $urandom_range(1, 40);
            lp         = 1'($urandom_range(0, 1));
            tgt        = $urandom_range(0, len - 1);
            nohit      = ($urandom_range(0, 2) == 0);
            m          = OUT_LEN'($urandom & 32'hFF) | (nohit ? UNREACH : '0);
            v          = OUT_LEN'(tbl[tgt][IN_LEN-1:0]) | (nohit ? UNREACH : '0);
            pause_at   = $urandom_range(0, len - 1);
            pause_len  = $urandom_range(1, 4);
            if (lp) begin
                stop_after = $urandom_range(1, 3 * len);
            end else begin
                stop_after = ($urandom_range(0, 1) == 1) ? $urandom_range(1, len) : 0;
            end
            run_case($sformatf("rnd%0d", t), len, lp, m, v, pause_at, pause_len, stop_after);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
